// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single synchronous memory port.
// M0 (processor) and M1 (DMA/display) share the port round-robin per access.
// A master may hold lock to burst up to MAX_BURST accesses while the peer waits.
// Read data is tagged with its owner and returned RD_LAT cycles after acceptance.
//
// Handshake: a master raises mx_req with mx_addr/mx_we/mx_wdata and keeps
// them stable while mx_req=1 and mx_gnt=0. The access is accepted in exactly
// the cycle where mx_req and mx_gnt are both high; that cycle drives mem_*.
// Dropping mx_req before acceptance withdraws the request with no access.
module mem_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W:0]   CNT_MAX = (CNT_W + 1)'(MAX_BURST);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [CNT_W:0]          cnt_inc;
    logic                    burst_done;
    logic                    last_owner;
    logic                    acc0, acc1, acc;
    rd_tag_t [RD_LAT-1:0]    rd_pipe;

    assign m0_gnt     = (state == GNT0);
    assign m1_gnt     = (state == GNT1);
    assign acc0       = m0_gnt & m0_req;
    assign acc1       = m1_gnt & m1_req;
    assign acc        = acc0 | acc1;
    assign cnt_inc    = {1'b0, cnt} + 1'b1;
    // The current access is the last one the lock may claim before yielding.
    assign burst_done = (cnt_inc >= CNT_MAX);
    assign dbg_state  = state;

    // Ownership state, tenure counter and tie-break history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (acc) begin
                last_owner <= acc1;
            end
        end
    end

    // Next owner: alternate on contention unless the owner holds a live lock.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_nxt = last_owner ? GNT0 : GNT1;
                end else if (m0_req) begin
                    state_nxt = GNT0;
                end else if (m1_req) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_req) begin
                    state_nxt = m1_req ? GNT1 : IDLE;
                end else if (m1_req && (!m0_lock || burst_done)) begin
                    state_nxt = GNT1;
                end
            end
            GNT1: begin
                if (!m1_req) begin
                    state_nxt = m0_req ? GNT0 : IDLE;
                end else if (m0_req && (!m1_lock || burst_done)) begin
                    state_nxt = GNT0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tenure counter: restarts on every ownership change, saturates at MAX_BURST.
    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (acc && ({1'b0, cnt} < CNT_MAX)) begin
            cnt_nxt = cnt_inc[CNT_W-1:0];
        end
    end

    // Memory port mux: idle port is driven to all zeros.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (acc0) begin
            mem_en    = 1'b1;
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (acc1) begin
            mem_en    = 1'b1;
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Read-return tag pipe, aligned with the memory's read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= '{valid: acc & ~mem_we, owner: acc1};
            for (int i = RD_LAT - 1; i > 0; i--) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign m0_rvalid = rd_pipe[RD_LAT-1].valid & ~rd_pipe[RD_LAT-1].owner;
    assign m1_rvalid = rd_pipe[RD_LAT-1].valid &  rd_pipe[RD_LAT-1].owner;
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// two-master traffic, checked against a cycle-level model of the arbitration
// rules and a shadow memory.
module tb_mem_port_arbiter;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 8;
    localparam int RD_LAT    = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              req   [2];
    logic              we    [2];
    logic              lock  [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];
    logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        dbg_state;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(req[0]), .m0_we(we[0]), .m0_lock(lock[0]),
        .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(req[1]), .m1_we(we[1]), .m1_lock(lock[1]),
        .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- synchronous memory ----------------
    function automatic logic [DATA_W-1:0] mem_init(input logic [ADDR_W-1:0] a);
        return (a == 16'h0010) ? 16'hBEEF : {a[7:0], ~a[7:0]};
    endfunction

    logic [DATA_W-1:0] mem_data [65536];
    bit                mem_wr   [65536];
    logic [DATA_W-1:0] rd_pipe  [RD_LAT];

    // Memory array with an RD_LAT-deep read data pipe.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_data[mem_addr] <= mem_wdata;
            mem_wr[mem_addr]   <= 1'b1;
        end
        if (mem_en && !mem_we) begin
            rd_pipe[0] <= mem_wr[mem_addr] ? mem_data[mem_addr] : mem_init(mem_addr);
        end else begin
            rd_pipe[0] <= '0;
        end
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // ---------------- reference model ----------------
    int                 own;           // -1 = nobody, else master index owning the port
    int                 cnt;           // accesses in current tenure
    int                 last;          // master of the most recent accepted access
    bit                 m_acc [2];     // master had an access accepted last cycle
    logic [DATA_W-1:0]  ref_mem [65536];
    bit                 ref_wr  [65536];
    logic [DATA_W+1:0]  exp_q [$];     // {valid, owner, data}, front = visible this cycle

    int errors = 0;
    int checks = 0;
    int obs_owner;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own = -1;
        cnt = 0;
        last = 1;
        m_acc[0] = 1'b0;
        m_acc[1] = 1'b0;
        exp_q.delete();
        repeat (RD_LAT) exp_q.push_back('0);
    endtask

    task automatic model_step();
        int   nown;
        int   y;
        bit   a;
        bit   rd;
        logic [DATA_W-1:0] d;
        a  = (own >= 0) ? req[own] : 1'b0;
        rd = 1'b0;
        d  = '0;
        m_acc[0] = 1'b0;
        m_acc[1] = 1'b0;
        if (a) begin
            m_acc[own] = 1'b1;
            last = own;
            if (we[own]) begin
                ref_mem[addr[own]] = wdata[own];
                ref_wr[addr[own]]  = 1'b1;
            end else begin
                rd = 1'b1;
                d  = ref_wr[addr[own]] ? ref_mem[addr[own]] : mem_init(addr[own]);
            end
        end
        if (own < 0) begin
            if (req[0] && req[1]) nown = 1 - last;
            else if (req[0])      nown = 0;
            else if (req[1])      nown = 1;
            else                  nown = -1;
        end else begin
            y = 1 - own;
            if (!req[own])                                          nown = req[y] ? y : -1;
            else if (req[y] && (!lock[own] || cnt + 1 >= MAX_BURST)) nown = y;
            else                                                    nown = own;
        end
        if (nown != own)                   cnt = 0;
        else if (a && cnt < MAX_BURST)     cnt = cnt + 1;
        exp_q.push_back({rd, own[0], d});
        void'(exp_q.pop_front());
        own = nown;
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic check_outputs();
        bit                a;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        logic [DATA_W+1:0] e;
        a = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (own >= 0) begin
            a = req[own];
            if (a) begin
                e_we = we[own]; e_addr = addr[own]; e_wd = wdata[own];
            end
        end
        e = exp_q[0];
        chk("m0_gnt", 32'(m0_gnt), 32'(own == 0));
        chk("m1_gnt", 32'(m1_gnt), 32'(own == 1));
        chk("mem_en", 32'(mem_en), 32'(a));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        chk("m0_rvalid", 32'(m0_rvalid), 32'(e[DATA_W+1] && !e[DATA_W]));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(e[DATA_W+1] && e[DATA_W]));
        if (e[DATA_W+1]) chk("rdata", 32'(rdata), 32'(e[DATA_W-1:0]));
        obs_owner = mem_en ? (m1_gnt ? 1 : 0) : -1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic sample();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset_n) model_step();
        else         model_reset();
        #1;
    endtask

    task automatic idle_masters();
        for (int x = 0; x < 2; x++) begin
            req[x] = 1'b0; we[x] = 1'b0; lock[x] = 1'b0; addr[x] = '0; wdata[x] = '0;
        end
    endtask

    task automatic drive_master(input int x);
        if (req[x] && !m_acc[x]) begin
            if ($urandom_range(0, 15) == 0) req[x] = 1'b0;
        end else begin
            req[x]   = ($urandom_range(0, 9) < 7);
            we[x]    = ($urandom_range(0, 2) == 0);
            addr[x]  = 16'($urandom_range(0, 31));
            wdata[x] = 16'($urandom);
        end
        lock[x] = ($urandom_range(0, 3) != 0);
    endtask

    // ---------------- stimulus ----------------
    int owners [4];
    int n0;
    bit hit, prev0, gap_ok;

    initial begin
        reset_n = 1'b0;
        idle_masters();
        model_reset();
        sample(); chk("rst_dbg_state", 32'(dbg_state), 32'd0); advance();
        sample(); advance();
        reset_n = 1'b1;

        // M0 read of 0x0010, memory holds 0xBEEF
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0010;
        sample(); chk("t2_gnt_c0", 32'(m0_gnt), 32'd0); advance();
        sample(); chk("t2_gnt_c1", 32'(m0_gnt), 32'd1);
        chk("t2_addr_c1", 32'(mem_addr), 32'h0010); advance();
        req[0] = 1'b0;
        sample(); chk("t2_rvalid_c2", 32'(m0_rvalid), 32'd1);
        chk("t2_rdata_c2", 32'(rdata), 32'hBEEF); advance();
        sample(); advance();

        // M1 write 0x0020 <- 0x1234 from idle
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0020; wdata[1] = 16'h1234;
        sample(); advance();
        sample(); chk("t5_we", 32'(mem_we), 32'd1);
        chk("t5_addr", 32'(mem_addr), 32'h0020);
        chk("t5_wdata", 32'(mem_wdata), 32'h1234); advance();
        req[1] = 1'b0;
        sample(); chk("t5_no_rvalid0", 32'(m0_rvalid), 32'd0);
        chk("t5_no_rvalid1", 32'(m1_rvalid), 32'd0); advance();
        sample(); advance();

        // Both masters reading continuously, no lock: strict alternation
        idle_masters();
        req[0] = 1'b1; addr[0] = 16'h0030;
        req[1] = 1'b1; addr[1] = 16'h0040;
        sample(); advance();
        for (int k = 0; k < 4; k++) begin
            sample(); owners[k] = obs_owner; advance();
        end
        idle_masters();
        for (int k = 0; k < 4; k++) chk($sformatf("t3_owner_%0d", k), 32'(owners[k]), 32'(k % 2));
        sample(); advance();
        sample(); advance();

        // M0 locked burst, M1 requests from cycle 2
        idle_masters();
        req[0] = 1'b1; lock[0] = 1'b1; addr[0] = 16'h0050;
        n0 = 0; hit = 1'b0; prev0 = 1'b0; gap_ok = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (c == 2) begin req[1] = 1'b1; addr[1] = 16'h0060; end
            sample();
            if (mem_en && m1_gnt) begin
                hit = 1'b1; gap_ok = prev0;
            end else begin
                prev0 = mem_en && m0_gnt;
                if (prev0) n0++;
            end
            advance();
        end
        idle_masters();
        chk("t4_m1_granted", 32'(hit), 32'd1);
        chk("t4_m0_burst", 32'(n0), 32'd8);
        chk("t4_no_bubble", 32'(gap_ok), 32'd1);
        sample(); advance();
        sample(); advance();

        // M0 read accepted, then reset before the data returns
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0070;
        sample(); advance();
        sample(); chk("t6_accept", 32'(mem_en), 32'd1);
        reset_n = 1'b0;
        #1;
        model_reset();
        advance();
        reset_n = 1'b1;
        sample(); chk("t6_no_rvalid", 32'(m0_rvalid), 32'd0);
        chk("t6_gnt_c0", 32'(m0_gnt), 32'd0); advance();
        sample(); chk("t6_gnt_c1", 32'(m0_gnt), 32'd1); advance();
        req[0] = 1'b0;
        sample(); advance();
        sample(); advance();

        // Random traffic with a reset asserted mid-stream
        for (int i = 0; i < 500; i++) begin
            if (i == 200) begin
                reset_n = 1'b0;
                model_reset();
                sample();
                chk("t1_m0_gnt", 32'(m0_gnt), 32'd0);
                chk("t1_m1_gnt", 32'(m1_gnt), 32'd0);
                chk("t1_m0_rvalid", 32'(m0_rvalid), 32'd0);
                chk("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);
                chk("t1_mem_en", 32'(mem_en), 32'd0);
                chk("t1_mem_we", 32'(mem_we), 32'd0);
                advance();
                reset_n = 1'b1;
            end
            drive_master(0);
            drive_master(1);
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
